// File: rtl/inst_fetch_pkg.sv
// Shared constants for the instruction fetch stage.
// Optional feature macro: FETCH_ADEF_EN adds the address-error (ADEF) bit and
// makes fetch suppress the SRAM request for misaligned addresses.
package inst_fetch_pkg;

    localparam int BR_BUS_WD = 33;

`ifdef FETCH_ADEF_EN
    localparam int FETCH_TO_DEC_BUS_WD = 65;
`else
    localparam int FETCH_TO_DEC_BUS_WD = 64;
`endif

    localparam logic [31:0] INST_NOP         = 32'h0340_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h1c00_0000;

    // A word fetch must sit on a 4-byte boundary
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/inst_fetch_hold_buf.sv
// One-entry instruction holder. SRAM read data is only valid for one cycle,
// so when decode stalls the word is captured here and replayed until accepted.
module inst_fetch_hold_buf (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] rdata,
    output logic        hold_valid,
    output logic [31:0] inst
);

    logic        hold_valid_r;
    logic [31:0] hold_inst_r;

    // Capture rdata on the first stall cycle only; later cycles carry garbage
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_valid_r <= 1'b0;
            hold_inst_r  <= 32'h0000_0000;
        end else if (clear) begin
            hold_valid_r <= 1'b0;
        end else if (load && !hold_valid_r) begin
            hold_valid_r <= 1'b1;
            hold_inst_r  <= rdata;
        end else begin
            hold_valid_r <= hold_valid_r;
        end
    end

    // Present the held word when present, otherwise the live SRAM data
    always_comb begin
        inst       = rdata;
        hold_valid = hold_valid_r;
        if (hold_valid_r) begin
            inst = hold_inst_r;
        end else begin
            inst = rdata;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// IF stage: computes nextpc, drives the synchronous instruction SRAM and
// presents one fetched instruction to decode. Decode redirects leave exactly
// one wrong-path instruction for decode to drop.
// Optional feature macro: FETCH_ADEF_EN (misaligned fetch -> ADEF + NOP).
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           dec_allowin,
    input  logic [BR_BUS_WD-1:0]           branch_bus,
    output logic                           fetch_to_dec_valid,
    output logic [FETCH_TO_DEC_BUS_WD-1:0] fetch_to_decode_bus,
    output logic                           inst_sram_en,
    output logic [3:0]                     inst_sram_we,
    output logic [31:0]                    inst_sram_addr,
    output logic [31:0]                    inst_sram_wdata,
    input  logic [31:0]                    inst_sram_rdata
);

    logic        to_fs_valid_r;
    logic        fs_valid_r;
    logic [31:0] fs_pc_r;
`ifdef FETCH_ADEF_EN
    logic        fs_adef_r;
    logic        nextpc_adef_s;
`endif

    logic        br_taken_s;
    logic [31:0] br_target_s;
    logic        br_commit_s;
    logic        fs_allowin_s;
    logic [31:0] nextpc_s;
    logic        req_s;
    logic        hold_load_s;
    logic        hold_clear_s;
    logic        hold_valid_s;
    logic [31:0] buf_inst_s;
    logic [31:0] fs_inst_s;

    // Pre-IF: next address and whether a request goes out this cycle
    always_comb begin
        br_taken_s   = branch_bus[32];
        br_target_s  = branch_bus[31:0];
        fs_allowin_s = !fs_valid_r || dec_allowin;
        // A taken branch only counts when it actually leaves decode
        br_commit_s  = br_taken_s && dec_allowin;
        if (br_commit_s) begin
            nextpc_s = br_target_s;
        end else begin
            nextpc_s = fs_pc_r + 32'd4;
        end
        req_s        = to_fs_valid_r && fs_allowin_s;
        hold_load_s  = fs_valid_r && !dec_allowin;
        hold_clear_s = req_s || (fs_valid_r && dec_allowin);
`ifdef FETCH_ADEF_EN
        nextpc_adef_s = is_misaligned(nextpc_s);
`endif
    end

    // pre-IF valid rises on the first edge after reset release
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_fs_valid_r <= 1'b0;
        end else begin
            to_fs_valid_r <= 1'b1;
        end
    end

    // IF stage valid/pc: load on request, drop when decode takes the instruction
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fs_valid_r <= 1'b0;
            fs_pc_r    <= RESET_PC - 32'd4;
`ifdef FETCH_ADEF_EN
            fs_adef_r  <= 1'b0;
`endif
        end else if (req_s) begin
            fs_valid_r <= 1'b1;
            fs_pc_r    <= nextpc_s;
`ifdef FETCH_ADEF_EN
            fs_adef_r  <= nextpc_adef_s;
`endif
        end else if (fs_valid_r && dec_allowin) begin
            fs_valid_r <= 1'b0;
        end else begin
            fs_valid_r <= fs_valid_r;
        end
    end

    inst_fetch_hold_buf u_hold_buf (
        .clk        (clk),
        .resetn     (resetn),
        .load       (hold_load_s),
        .clear      (hold_clear_s),
        .rdata      (inst_sram_rdata),
        .hold_valid (hold_valid_s),
        .inst       (buf_inst_s)
    );

    // SRAM request and decode-facing bus
    always_comb begin
        inst_sram_we    = 4'b0000;
        inst_sram_wdata = 32'h0000_0000;
        inst_sram_addr  = nextpc_s;
`ifdef FETCH_ADEF_EN
        // Misaligned fetch still advances IF but never touches the SRAM
        inst_sram_en = req_s && !nextpc_adef_s;
        if (fs_adef_r) begin
            fs_inst_s = INST_NOP;
        end else begin
            fs_inst_s = buf_inst_s;
        end
        fetch_to_decode_bus = {fs_adef_r, fs_inst_s, fs_pc_r};
`else
        inst_sram_en        = req_s;
        fs_inst_s           = buf_inst_s;
        fetch_to_decode_bus = {fs_inst_s, fs_pc_r};
`endif
        fetch_to_dec_valid = fs_valid_r;
    end

endmodule
